// File: rtl/linebuf_ctrl.sv
// Read-address sequencer and window tagger for a 5x5 sliding-window line buffer.
// Streams one frame from a synchronous RAM and flags complete in-image windows.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// READ  | issuing one RAM address per cycle, raster order
// DRAIN | RAM/line-buffer pipeline empties, no reads
// DONE  | one-cycle frame-end pulse
module linebuf_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int IMGW   = 12,
  parameter int IMGH   = 12,
  parameter int FSIZE  = 5
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_re,
  output logic              win_valid,
  output logic [7:0]        win_x,
  output logic [7:0]        win_y,
  output logic              busy,
  output logic              done
);

  localparam int CW        = (IMGW > 1) ? $clog2(IMGW) : 1;
  localparam int RW        = (IMGH > 1) ? $clog2(IMGH) : 1;
  localparam int DRAIN_LEN = 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMGW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMGH - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(FSIZE - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(FSIZE - 1);

  // Window coordinates are 8 bits wide, and the window must fit in the image.
  if (FSIZE > IMGW || FSIZE > IMGH || IMGW > 256 || IMGH > 256 || DWIDTH < 1) begin : g_cfg_err
    $error("linebuf_ctrl: inconsistent parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tag_v1_q, tag_v1_d;
  logic [7:0]        tag_x1_q, tag_x1_d;
  logic [7:0]        tag_y1_q, tag_y1_d;
  logic              win_valid_q, win_valid_d;
  logic [7:0]        win_x_q, win_x_d;
  logic [7:0]        win_y_q, win_y_d;

  logic              tag;
  logic [7:0]        tag_x;
  logic [7:0]        tag_y;

  // Tag describes the pixel being issued this cycle as a window's bottom-right corner.
  assign tag   = mem_re_q && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
  assign tag_x = 8'(col_q - COL_MIN);
  assign tag_y = 8'(row_q - ROW_MIN);

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = mem_re_q;
    col_d       = col_q;
    row_d       = row_q;
    drain_cnt_d = drain_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    tag_v1_d    = tag;
    tag_x1_d    = tag ? tag_x : tag_x1_q;
    tag_y1_d    = tag ? tag_y : tag_y1_q;
    win_valid_d = tag_v1_q;
    win_x_d     = tag_v1_q ? tag_x1_q : win_x_q;
    win_y_d     = tag_v1_q ? tag_y1_q : win_y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = READ;
          mem_addr_d = base_addr;
          mem_re_d   = 1'b1;
          busy_d     = 1'b1;
          col_d      = '0;
          row_d      = '0;
        end
      end
      READ: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d     = DRAIN;
            mem_re_d    = 1'b0;
            drain_cnt_d = 2'(DRAIN_LEN - 1);
          end else begin
            row_d      = row_q + 1'b1;
            mem_addr_d = mem_addr_q + 1'b1;
          end
        end else begin
          col_d      = col_q + 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == 2'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        mem_re_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tag_v1_q    <= 1'b0;
      tag_x1_q    <= '0;
      tag_y1_q    <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tag_v1_q    <= tag_v1_d;
      tag_x1_q    <= tag_x1_d;
      tag_y1_q    <= tag_y1_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign win_valid = win_valid_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Scoreboard bench for linebuf_ctrl: expected reads, windows and done pulses are
// queued at stimulus time and consumed by an independent monitor.
module tb_linebuf_ctrl;

  localparam int AW = 12;
  localparam int W  = 12;
  localparam int H  = 12;
  localparam int F  = 5;

  logic          clk;
  logic          xrst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          win_valid;
  logic [7:0]    win_x;
  logic [7:0]    win_y;
  logic          busy;
  logic          done;

  linebuf_ctrl #(
    .DWIDTH(16), .AWIDTH(AW), .IMGW(W), .IMGH(H), .FSIZE(F)
  ) dut (
    .clk(clk), .xrst(xrst), .start(start), .base_addr(base_addr),
    .mem_addr(mem_addr), .mem_re(mem_re), .win_valid(win_valid),
    .win_x(win_x), .win_y(win_y), .busy(busy), .done(done)
  );

  typedef struct { int cyc; int addr; } rd_t;
  typedef struct { int cyc; int x; int y; } win_t;

  rd_t  rd_q[$];
  win_t win_q[$];
  int   done_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   cyc0   = 0;
  bit   mon_en = 0;
  int   last_x = 0;
  int   last_y = 0;
  int   win_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always begin : monitor
    rd_t  r;
    win_t w;
    int   rel;
    int   dc;
    @(posedge clk);
    #1;
    if (mon_en) begin
      rel = cyc - cyc0;
      check("busy", int'(busy), int'(rel >= 1 && rel <= W*H+3));
      if (mem_re) begin
        if (rd_q.size() == 0) check("unexpected_read_addr", int'(mem_addr), -1);
        else begin
          r = rd_q.pop_front();
          check("read_cycle", rel, r.cyc);
          check("read_addr", int'(mem_addr), r.addr);
        end
      end
      if (win_valid) begin
        check("win_x_in_range", int'(win_x <= 8'd7), 1);
        if (win_q.size() == 0) check("unexpected_window_cycle", rel, -1);
        else begin
          w = win_q.pop_front();
          check("win_cycle", rel, w.cyc);
          check("win_x", int'(win_x), w.x);
          check("win_y", int'(win_y), w.y);
          last_x = w.x;
          last_y = w.y;
          win_seen++;
        end
      end else begin
        check("win_x_hold", int'(win_x), last_x);
        check("win_y_hold", int'(win_y), last_y);
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done_cycle", rel, -1);
        else begin
          dc = done_q.pop_front();
          check("done_cycle", rel, dc);
        end
      end
    end
  end

  task automatic wait_rel(input int n);
    while (cyc - cyc0 < n) @(negedge clk);
  endtask

  // Pushes the full expected frame, then pulses start at the current negedge.
  task automatic start_frame(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    rd_t  r;
    win_t w;
    for (int row = 0; row < H; row++) begin
      for (int col = 0; col < W; col++) begin
        a      = base + AW'(row*W + col);
        r.cyc  = row*W + col + 1;
        r.addr = int'(a);
        rd_q.push_back(r);
        if (row >= F-1 && col >= F-1) begin
          w.cyc = r.cyc + 2;
          w.x   = col - (F-1);
          w.y   = row - (F-1);
          win_q.push_back(w);
        end
      end
    end
    done_q.push_back(W*H + 3);
    win_seen  = 0;
    cyc0      = cyc;
    mon_en    = 1;
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 12'hABC;
  endtask

  task automatic end_frame(input string tag);
    wait_rel(W*H + 8);
    check({tag, "_reads_left"}, rd_q.size(), 0);
    check({tag, "_windows_left"}, win_q.size(), 0);
    check({tag, "_done_left"}, done_q.size(), 0);
    check({tag, "_window_count"}, win_seen, (W-F+1)*(H-F+1));
    check({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic pulse_start(input logic [AW-1:0] b);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    start     = 1'b0;
  endtask

  initial begin
    xrst      = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_re", int'(mem_re), 0);
    check("rst_win_valid", int'(win_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    xrst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame from address 0.
    start_frame(12'h000);
    end_frame("base0");

    // Address wrap-around.
    start_frame(12'hFF0);
    end_frame("wrap");

    // Starts during READ and during DONE must be ignored.
    start_frame(12'h000);
    wait_rel(10);
    pulse_start(12'h555);
    wait_rel(W*H + 3);
    pulse_start(12'h555);
    end_frame("ignore");
    repeat (5) begin
      @(negedge clk);
      check("ignore_no_restart_re", int'(mem_re), 0);
    end

    // Asynchronous reset mid-frame.
    start_frame(12'h000);
    wait_rel(80);
    mon_en = 0;
    #2;
    xrst = 1'b0;
    #1;
    check("arst_mem_addr", int'(mem_addr), 0);
    check("arst_mem_re", int'(mem_re), 0);
    check("arst_win_valid", int'(win_valid), 0);
    check("arst_win_x", int'(win_x), 0);
    check("arst_win_y", int'(win_y), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    rd_q.delete();
    win_q.delete();
    done_q.delete();
    last_x = 0;
    last_y = 0;
    for (int c = 81; c < 90; c++) begin
      wait_rel(c);
      if (c == 82) xrst = 1'b1;
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_done", int'(done), 0);
      check("post_rst_re", int'(mem_re), 0);
    end
    wait_rel(90);
    start_frame(12'h000);
    end_frame("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
